apb_master_arb: RTL and testbench

Two-port APB master that shares the I2C register-file APB slave between two on-chip requesters (e.g. host CPU bridge and a DMA/sequencer). It arbitrates round-robin, drives the SETUP/ACCESS phases, enforces the register ownership map, and returns read data, completion and error per requester. It sits directly in front of the APB slave's PSEL/PEN/PW/PADDR/PWDATA/PRDATA/PREADY pins.

---
 rtl/apb_master_arb.sv | 148 ++++++++++++++
 tb/tb_apb_master_arb.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arb.sv
// rtl/apb_master_arb.sv - two-port round-robin APB master with ownership check and wait timeout
module apb_master_arb #(
  parameter int size    = 32,
  parameter int ad_size = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               we0,
  input  logic [ad_size-1:0] addr0,
  input  logic [size-1:0]    wdata0,
  input  logic               req1,
  input  logic               we1,
  input  logic [ad_size-1:0] addr1,
  input  logic [size-1:0]    wdata1,
  output logic               done0,
  output logic               err0,
  output logic [size-1:0]    rdata0,
  output logic               done1,
  output logic               err1,
  output logic [size-1:0]    rdata1,
  output logic               PSEL,
  output logic               PEN,
  output logic               PW,
  output logic [ad_size-1:0] PADDR,
  output logic [size-1:0]    PWDATA,
  input  logic [size-1:0]    PRDATA,
  input  logic               PREADY
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t          state_q;
  logic            ptr_q;
  logic            gnt_q;
  logic            we_q;
  logic [CW-1:0]   cnt_q;

  logic               sel;
  logic               sel_we;
  logic [ad_size-1:0] sel_addr;
  logic [size-1:0]    sel_wdata;
  logic               sel_reject;

  // Pick the port to serve: the lone requester, or the pointer's port when both ask
  always_comb begin
    sel = 1'b0;
    if (req0 && req1) begin
      sel = ptr_q;
    end else if (req1) begin
      sel = 1'b1;
    end
  end

  assign sel_we     = sel ? we1 : we0;
  assign sel_addr   = sel ? addr1 : addr0;
  assign sel_wdata  = sel ? wdata1 : wdata0;
  // Registers 4 and above belong to the I2C engine; the bus may only read them
  assign sel_reject = sel_we && (sel_addr > ad_size'(3));

  // Transfer sequencer: arbitration, APB phases, timeout and per-port completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      done0   <= 1'b0;
      err0    <= 1'b0;
      rdata0  <= '0;
      done1   <= 1'b0;
      err1    <= 1'b0;
      rdata1  <= '0;
      PSEL    <= 1'b0;
      PEN     <= 1'b0;
      PW      <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            gnt_q <= sel;
            we_q  <= sel_we;
            if (req0 && req1) begin
              ptr_q <= ~ptr_q;
            end
            if (sel_reject) begin
              state_q <= DONE;
              done0   <= ~sel;
              done1   <= sel;
              err0    <= ~sel;
              err1    <= sel;
            end else begin
              state_q <= SETUP;
              PSEL    <= 1'b1;
              PEN     <= 1'b0;
              PW      <= sel_we;
              PADDR   <= sel_addr;
              PWDATA  <= sel_we ? sel_wdata : '0;
            end
          end
        end
        SETUP: begin
          state_q <= ACCESS;
          PEN     <= 1'b1;
          cnt_q   <= '0;
        end
        ACCESS: begin
          if (PREADY || (cnt_q == CW'(TIMEOUT - 1))) begin
            state_q <= DONE;
            PSEL    <= 1'b0;
            PEN     <= 1'b0;
            PW      <= 1'b0;
            done0   <= ~gnt_q;
            done1   <= gnt_q;
            err0    <= ~gnt_q && !PREADY;
            err1    <= gnt_q && !PREADY;
            if (PREADY && !we_q) begin
              if (gnt_q) begin
                rdata1 <= PRDATA;
              end else begin
                rdata0 <= PRDATA;
              end
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done0   <= 1'b0;
          done1   <= 1'b0;
          err0    <= 1'b0;
          err1    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// tb/tb_apb_master_arb.sv - directed vector bench for apb_master_arb
module tb_apb_master_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        done0, err0, done1, err1;
  logic [31:0] rdata0, rdata1;
  logic        PSEL, PEN, PW;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  int pen_cnt = 0;

  apb_master_arb #(.size(32), .ad_size(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .done0(done0), .err0(err0), .rdata0(rdata0),
    .done1(done1), .err1(err1), .rdata1(rdata1),
    .PSEL(PSEL), .PEN(PEN), .PW(PW), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 clk = ~clk;

  // Slave model: mode 0 zero-wait, mode 1 never ready, mode 2 two wait states
  assign PREADY = PSEL & PEN & ((mode == 0) || ((mode == 2) && (pen_cnt >= 2)));

  always @(posedge clk) begin
    if (PSEL && PEN) pen_cnt <= pen_cnt + 1;
    else pen_cnt <= 0;
  end

  typedef struct {
    logic        r0; logic w0; logic [7:0] a0; logic [31:0] d0;
    logic        r1; logic w1; logic [7:0] a1; logic [31:0] d1;
    logic [31:0] prd;
    int          md;
    int          port;
    logic        err;
    int          lat;
    int          psel_cyc;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic        exp_we;
    logic [7:0]  exp_addr;
    logic [31:0] exp_wd;
    int lat, psel_n, bad;
    @(negedge clk);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    PRDATA = v.prd; mode = v.md;
    exp_we   = (v.port == 1) ? v.w1 : v.w0;
    exp_addr = (v.port == 1) ? v.a1 : v.a0;
    exp_wd   = exp_we ? ((v.port == 1) ? v.d1 : v.d0) : 32'h0;
    lat = 0; psel_n = 0; bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (PSEL) begin
        psel_n++;
        if (PW !== exp_we || PADDR !== exp_addr || PWDATA !== exp_wd) bad++;
      end
      if (done0 || done1) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_done"}, {done1, done0}, (v.port == 1) ? 32'd2 : 32'd1);
    chk({tag, "_err"}, {err1, err0}, v.err ? ((v.port == 1) ? 32'd2 : 32'd1) : 32'd0);
    chk({tag, "_rdata0"}, rdata0, v.rd0);
    chk({tag, "_rdata1"}, rdata1, v.rd1);
    chk({tag, "_psel_cycles"}, psel_n, v.psel_cyc);
    chk({tag, "_apb_fields"}, bad, 0);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, {PSEL, PEN, PW, done0, done1}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int got;
    //            r0   w0   a0     d0            r1   w1   a1     d1            prd           md port err  lat psel rd0           rd1
    vecs[0] = '{1'b1,1'b1,8'h01,32'h0000_00A5,1'b0,1'b0,8'h00,32'h0,        32'h0,        0, 0, 1'b0, 3,  2, 32'h0,        32'h0};
    vecs[1] = '{1'b0,1'b0,8'h00,32'h0,        1'b1,1'b0,8'h04,32'h0,        32'h1234_5678,0, 1, 1'b0, 3,  2, 32'h0,        32'h1234_5678};
    vecs[2] = '{1'b1,1'b0,8'h02,32'h0,        1'b0,1'b0,8'h00,32'h0,        32'hCAFE_F00D,0, 0, 1'b0, 3,  2, 32'hCAFE_F00D,32'h1234_5678};
    vecs[3] = '{1'b1,1'b1,8'h05,32'h77,       1'b0,1'b0,8'h00,32'h0,        32'h0,        0, 0, 1'b1, 1,  0, 32'hCAFE_F00D,32'h1234_5678};
    vecs[4] = '{1'b0,1'b0,8'h00,32'h0,        1'b1,1'b0,8'h07,32'h0,        32'hFFFF_FFFF,1, 1, 1'b1, 18, 17,32'hCAFE_F00D,32'h1234_5678};
    vecs[5] = '{1'b0,1'b0,8'h00,32'h0,        1'b1,1'b1,8'h03,32'hDEAD_BEEF,32'h0,        2, 1, 1'b0, 5,  4, 32'hCAFE_F00D,32'h1234_5678};
    vecs[6] = '{1'b1,1'b1,8'h04,32'h55,       1'b0,1'b0,8'h00,32'h0,        32'h0,        0, 0, 1'b1, 1,  0, 32'hCAFE_F00D,32'h1234_5678};
    vecs[7] = '{1'b0,1'b0,8'h00,32'h0,        1'b1,1'b0,8'hFF,32'h0,        32'h5A5A_0000,0, 1, 1'b0, 3,  2, 32'hCAFE_F00D,32'h5A5A_0000};
    vecs[8] = '{1'b1,1'b0,8'h00,32'h0,        1'b0,1'b0,8'h00,32'h0,        32'h0000_0001,2, 0, 1'b0, 5,  4, 32'h0000_0001,32'h5A5A_0000};

    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'h0; wdata0 = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'h0; wdata1 = 32'h0;
    PRDATA = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_apb", {PSEL, PEN, PW}, 0);
    chk("reset_paddr", PADDR, 0);
    chk("reset_pwdata", PWDATA, 0);
    chk("reset_done_err", {done0, err0, done1, err1}, 0);
    chk("reset_rdata0", rdata0, 0);
    chk("reset_rdata1", rdata1, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Both ports held high: grants must alternate 0,1,0,1
    @(negedge clk);
    mode = 0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h01; wdata0 = 32'h1111_0000;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h02; wdata1 = 32'h2222_0000;
    for (int t = 0; t < 4; t++) begin
      got = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done0 || done1) begin
          got = 1;
          break;
        end
      end
      chk($sformatf("rr%0d_seen", t), got, 1);
      chk($sformatf("rr%0d_port", t), {done1, done0}, (t % 2 == 1) ? 32'd2 : 32'd1);
      chk($sformatf("rr%0d_psel_done", t), {PSEL, PEN}, 0);
      @(negedge clk);
      chk($sformatf("rr%0d_psel_idle", t), {PSEL, PEN}, 0);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Reset in the middle of an ACCESS phase aborts without a done
    @(negedge clk);
    mode = 1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h02; wdata0 = 32'h0000_0011;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("mid_access_pen", {PSEL, PEN, PW}, 3'b111);
    #2 rst = 1'b1;
    #1 chk("mid_reset_async", {PSEL, PEN, PW}, 0);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("mid_reset_done", {done0, done1}, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset_nodone%0d", k), {done0, done1, PSEL}, 0);
    end

    v = '{1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,8'h10,32'h0, 32'h0BAD_F00D, 0, 1, 1'b0, 3, 2, 32'h0, 32'h0BAD_F00D};
    run_vec(v, "post_reset_req1");
    v = '{1'b1,1'b1,8'h03,32'h0000_0033, 1'b1,1'b0,8'h01,32'h0, 32'h0, 0, 0, 1'b0, 3, 2, 32'h0, 32'h0BAD_F00D};
    run_vec(v, "post_reset_ptr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
